main_fsm_hs: RTL and testbench

- Parametrised multi-cycle RV32I control FSM; successor of main_fsm.
- Adds async active-low reset, a memory ready handshake with wait states, lui/auipc/jalr, and illegal-opcode and bus-timeout trapping.
- Sits in the multi-cycle controller beside the ALU decoder.
- Drives the datapath muxes and strobes; the datapath is unchanged except alu_srcA=11 selects constant zero.

---
 rtl/main_fsm_hs_pkg.sv | 85 ++++++++
 rtl/main_fsm_hs_mem_wait_timer.sv | 37 +++
 rtl/main_fsm_hs.sv | 262 ++++++++++++++++++++++++++
 tb/tb_main_fsm_hs.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_hs_pkg.sv
// Purpose : shared definitions for the main_fsm_hs multi-cycle RV32I controller.
// Contents: opcode constants, 5-bit state encoding, datapath mux select codes,
//           the packed control bundle driven by the FSM, and the wait-counter
//           width helper.
package main_fsm_hs_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 5;

  // RV32I major opcodes
  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I     = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OP_W-1:0] OP_BR    = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMREAD  = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWRITE = 5'd5,
    S_EXECR    = 5'd6,
    S_EXECI    = 5'd7,
    S_ALUWB    = 5'd8,
    S_BRANCH   = 5'd9,
    S_JAL      = 5'd10,
    S_JALRADR  = 5'd11,
    S_LUI      = 5'd12,
    S_TRAP     = 5'd13
  } state_e;

  // result_src
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // alu_srcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // alu_srcB
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // alu_op
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // adr_src
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // Control bundle presented to the datapath
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_update;
    logic       reg_write;
    logic       branch;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Wait counter must hold 0..timeout inclusive; never narrower than 1 bit.
  function automatic int unsigned timer_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/main_fsm_hs_mem_wait_timer.sv
// Purpose : counts memory wait cycles and flags when the allowed number of
//           wait cycles has been used up.
// Ports   : clk, rst_n      - clock, async active-low reset
//           i_clr           - restart count (a new state is being entered)
//           i_inc           - a request is outstanding without ready
//           o_expired_c     - count equals MEM_TIMEOUT (combinational)
module mem_wait_timer
  import main_fsm_hs_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired_c
);

  localparam int unsigned         CNT_W = timer_width(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]    LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Wait-cycle counter; the FSM leaves the state on expiry, which clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired_c = (r_cnt == LIMIT);

endmodule

// File: rtl/main_fsm_hs.sv
// Purpose : multi-cycle RV32I main control FSM with memory ready handshake,
//           lui/auipc/jalr support, illegal-opcode and bus-timeout trapping.
// Ports   : clk, rst_n            - clock, async active-low reset
//           op                    - opcode from instruction register
//           mem_ready             - memory completes access this cycle
//           mem_req, mem_write    - memory request / write qualifier
//           ir_write, pc_update   - IR load, unconditional PC write
//           reg_write, branch     - RF write, branch evaluate strobe
//           result_src, alu_srcA, alu_srcB, adr_src, alu_op - datapath muxes
//           illegal, bus_err      - illegal opcode flag, sticky timeout flag
//           state_o               - current state code
module main_fsm_hs
  import main_fsm_hs_pkg::*;
#(
  parameter bit          ENABLE_UJ       = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned MEM_TIMEOUT     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               branch,
  output logic               pc_update,
  output logic               reg_write,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_srcA,
  output logic [1:0]         alu_srcB,
  output logic               adr_src,
  output logic [1:0]         alu_op,
  output logic               illegal,
  output logic               bus_err,
  output logic [STATE_W-1:0] state_o
);

  state_e r_state;
  state_e w_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_q;
  logic   r_illegal;
  logic   r_bus_err;
  logic   w_op_illegal;
  logic   w_trap_illegal;
  logic   w_trap_bus;
  logic   w_expired;

  // State and sticky trap-cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | w_trap_illegal;
      r_bus_err <= r_bus_err | w_trap_bus;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next         = r_state;
    w_ctrl         = '0;
    w_op_illegal   = 1'b0;
    w_trap_illegal = 1'b0;
    w_trap_bus     = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.adr_src    = ADR_PC;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALURES;
        if (mem_ready) begin
          w_ctrl.ir_write  = 1'b1;
          w_ctrl.pc_update = 1'b1;
          w_next           = S_DECODE;
        end else if (w_expired) begin
          w_next     = S_TRAP;
          w_trap_bus = 1'b1;
        end
      end

      S_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BR:        w_next = S_BRANCH;
          OP_JALR: begin
            if (ENABLE_UJ) w_next = S_JALRADR;
            else           w_op_illegal = 1'b1;
          end
          OP_LUI: begin
            if (ENABLE_UJ) w_next = S_LUI;
            else           w_op_illegal = 1'b1;
          end
          // ALUOut already holds OldPC + imm from this cycle's add
          OP_AUIPC: begin
            if (ENABLE_UJ) w_next = S_ALUWB;
            else           w_op_illegal = 1'b1;
          end
          default:      w_op_illegal = 1'b1;
        endcase
        if (w_op_illegal) begin
          if (TRAP_ON_ILLEGAL) begin
            w_next         = S_TRAP;
            w_trap_illegal = 1'b1;
          end else begin
            w_next = S_FETCH;
          end
        end
      end

      S_MEMADR: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_next           = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.adr_src    = ADR_RESULT;
        w_ctrl.result_src = RES_ALUOUT;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_expired) begin
          w_next     = S_TRAP;
          w_trap_bus = 1'b1;
        end
      end

      S_MEMWB: begin
        w_ctrl.result_src = RES_DATA;
        w_ctrl.reg_write  = 1'b1;
        w_next            = S_FETCH;
      end

      // mem_write stays high across wait cycles until the write is accepted
      S_MEMWRITE: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.mem_write  = 1'b1;
        w_ctrl.adr_src    = ADR_RESULT;
        w_ctrl.result_src = RES_ALUOUT;
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_expired) begin
          w_next     = S_TRAP;
          w_trap_bus = 1'b1;
        end
      end

      S_EXECR: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_RD2;
        w_ctrl.alu_op    = ALUOP_FUNCT;
        w_next           = S_ALUWB;
      end

      S_EXECI: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_FUNCT;
        w_next           = S_ALUWB;
      end

      S_LUI: begin
        w_ctrl.alu_src_a = SRCA_ZERO;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_next           = S_ALUWB;
      end

      S_ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_write  = 1'b1;
        w_next            = S_FETCH;
      end

      S_BRANCH: begin
        w_ctrl.alu_src_a  = SRCA_RD1;
        w_ctrl.alu_src_b  = SRCB_RD2;
        w_ctrl.alu_op     = ALUOP_SUB;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.branch     = 1'b1;
        w_next            = S_FETCH;
      end

      S_JALRADR: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_next           = S_JAL;
      end

      // Writes the jump target into PC while computing OldPC + 4 for rd
      S_JAL: begin
        w_ctrl.alu_src_a  = SRCA_OLDPC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_update  = 1'b1;
        w_next            = S_ALUWB;
      end

      // Only reset leaves TRAP; all strobes stay low
      S_TRAP: w_next = S_TRAP;

      default: w_next = S_FETCH;
    endcase
  end

  // Wait-cycle timeout, present only when a limit is configured
  if (MEM_TIMEOUT > 0) begin : g_timer
    logic w_cnt_clr;
    logic w_cnt_inc;

    assign w_cnt_clr = (w_next != r_state);
    assign w_cnt_inc = w_ctrl.mem_req & ~mem_ready;

    mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_cnt_clr),
      .i_inc      (w_cnt_inc),
      .o_expired_c(w_expired)
    );
  end else begin : g_no_timer
    assign w_expired = 1'b0;
  end

  // Reset gates the decode so an in-flight request drops immediately
  assign w_ctrl_q = rst_n ? w_ctrl : '0;

  assign mem_req    = w_ctrl_q.mem_req;
  assign mem_write  = w_ctrl_q.mem_write;
  assign ir_write   = w_ctrl_q.ir_write;
  assign pc_update  = w_ctrl_q.pc_update;
  assign reg_write  = w_ctrl_q.reg_write;
  assign branch     = w_ctrl_q.branch;
  assign adr_src    = w_ctrl_q.adr_src;
  assign result_src = w_ctrl_q.result_src;
  assign alu_srcA   = w_ctrl_q.alu_src_a;
  assign alu_srcB   = w_ctrl_q.alu_src_b;
  assign alu_op     = w_ctrl_q.alu_op;
  assign illegal    = rst_n & (r_illegal | w_op_illegal);
  assign bus_err    = r_bus_err;
  assign state_o    = r_state;

endmodule

// File: tb/tb_main_fsm_hs.sv
// Purpose : directed self-checking bench for main_fsm_hs.
//           dut_a: ENABLE_UJ=1, TRAP_ON_ILLEGAL=1, MEM_TIMEOUT=3
//           dut_b: ENABLE_UJ=1, TRAP_ON_ILLEGAL=0, MEM_TIMEOUT=0
//           Both share clock and inputs.
module tb_main_fsm_hs;
  import main_fsm_hs_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       mem_ready;

  logic       a_mem_req, a_branch, a_pc_update, a_reg_write, a_mem_write, a_ir_write;
  logic [1:0] a_result_src, a_alu_srcA, a_alu_srcB, a_alu_op;
  logic       a_adr_src, a_illegal, a_bus_err;
  logic [4:0] a_state_o;

  logic       b_mem_req, b_branch, b_pc_update, b_reg_write, b_mem_write, b_ir_write;
  logic [1:0] b_result_src, b_alu_srcA, b_alu_srcB, b_alu_op;
  logic       b_adr_src, b_illegal, b_bus_err;
  logic [4:0] b_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // strobes {mem_req, ir_write, pc_update, reg_write, mem_write, branch}
  localparam logic [5:0] SB_NONE  = 6'b000000;
  localparam logic [5:0] SB_FRDY  = 6'b111000;
  localparam logic [5:0] SB_REQ   = 6'b100000;
  localparam logic [5:0] SB_WR    = 6'b100010;
  localparam logic [5:0] SB_WB    = 6'b000100;
  localparam logic [5:0] SB_PC    = 6'b001000;
  localparam logic [5:0] SB_BR    = 6'b000001;
  // muxes {adr_src, result_src, alu_srcA, alu_srcB, alu_op}
  localparam logic [8:0] MX_NONE  = 9'b0_00_00_00_00;
  localparam logic [8:0] MX_FETCH = 9'b0_10_00_10_00;
  localparam logic [8:0] MX_DEC   = 9'b0_00_01_01_00;
  localparam logic [8:0] MX_ADR   = 9'b0_00_10_01_00;
  localparam logic [8:0] MX_MEM   = 9'b1_00_00_00_00;
  localparam logic [8:0] MX_MWB   = 9'b0_01_00_00_00;
  localparam logic [8:0] MX_EXR   = 9'b0_00_10_00_10;
  localparam logic [8:0] MX_LUI   = 9'b0_00_11_01_00;
  localparam logic [8:0] MX_JAL   = 9'b0_00_01_10_00;
  localparam logic [8:0] MX_BR    = 9'b0_00_10_00_01;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  main_fsm_hs #(.ENABLE_UJ(1'b1), .TRAP_ON_ILLEGAL(1'b1), .MEM_TIMEOUT(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .branch(a_branch), .pc_update(a_pc_update),
    .reg_write(a_reg_write), .mem_write(a_mem_write), .ir_write(a_ir_write),
    .result_src(a_result_src), .alu_srcA(a_alu_srcA), .alu_srcB(a_alu_srcB),
    .adr_src(a_adr_src), .alu_op(a_alu_op), .illegal(a_illegal),
    .bus_err(a_bus_err), .state_o(a_state_o)
  );

  main_fsm_hs #(.ENABLE_UJ(1'b1), .TRAP_ON_ILLEGAL(1'b0), .MEM_TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .branch(b_branch), .pc_update(b_pc_update),
    .reg_write(b_reg_write), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .result_src(b_result_src), .alu_srcA(b_alu_srcA), .alu_srcB(b_alu_srcB),
    .adr_src(b_adr_src), .alu_op(b_alu_op), .illegal(b_illegal),
    .bus_err(b_bus_err), .state_o(b_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare one DUT's full output set against hand-written expectations
  task automatic look(input int sel, input string tag, input logic [4:0] st,
                      input logic [5:0] sb, input logic [8:0] mx, input logic [1:0] fl);
    logic [4:0] g_st;
    logic [5:0] g_sb;
    logic [8:0] g_mx;
    logic [1:0] g_fl;
    string      who;
    if (sel == 0) begin
      who  = "a.";
      g_st = a_state_o;
      g_sb = {a_mem_req, a_ir_write, a_pc_update, a_reg_write, a_mem_write, a_branch};
      g_mx = {a_adr_src, a_result_src, a_alu_srcA, a_alu_srcB, a_alu_op};
      g_fl = {a_illegal, a_bus_err};
    end else begin
      who  = "b.";
      g_st = b_state_o;
      g_sb = {b_mem_req, b_ir_write, b_pc_update, b_reg_write, b_mem_write, b_branch};
      g_mx = {b_adr_src, b_result_src, b_alu_srcA, b_alu_srcB, b_alu_op};
      g_fl = {b_illegal, b_bus_err};
    end
    check({who, tag, ".state"},   32'(g_st), 32'(st));
    check({who, tag, ".strobes"}, 32'(g_sb), 32'(sb));
    check({who, tag, ".muxes"},   32'(g_mx), 32'(mx));
    check({who, tag, ".flags"},   32'(g_fl), 32'(fl));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: sample on the falling edge, then advance past the rising edge
  task automatic cyc(input bit both, input string tag, input logic [4:0] st,
                     input logic [5:0] sb, input logic [8:0] mx, input logic [1:0] fl);
    @(negedge clk);
    look(0, tag, st, sb, mx, fl);
    if (both) look(1, tag, st, sb, mx, fl);
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    look(0, tag, S_FETCH, SB_NONE, MX_NONE, 2'b00);
    look(1, tag, S_FETCH, SB_NONE, MX_NONE, 2'b00);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    op        = OP_LW;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // lw, zero wait states
    do_reset("rst");
    cyc(1, "lw.fetch",  S_FETCH,   SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "lw.dec",    S_DECODE,  SB_NONE, MX_DEC,   2'b00);
    cyc(1, "lw.adr",    S_MEMADR,  SB_NONE, MX_ADR,   2'b00);
    cyc(1, "lw.rd",     S_MEMREAD, SB_REQ,  MX_MEM,   2'b00);
    cyc(1, "lw.wb",     S_MEMWB,   SB_WB,   MX_MWB,   2'b00);

    // sw with two wait states
    op = OP_SW;
    cyc(1, "sw.fetch",  S_FETCH,    SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "sw.dec",    S_DECODE,   SB_NONE, MX_DEC,   2'b00);
    cyc(1, "sw.adr",    S_MEMADR,   SB_NONE, MX_ADR,   2'b00);
    mem_ready = 1'b0;
    cyc(1, "sw.wait1",  S_MEMWRITE, SB_WR,   MX_MEM,   2'b00);
    cyc(1, "sw.wait2",  S_MEMWRITE, SB_WR,   MX_MEM,   2'b00);
    mem_ready = 1'b1;
    cyc(1, "sw.done",   S_MEMWRITE, SB_WR,   MX_MEM,   2'b00);

    // R-type with a fetch wait: ir_write only on the ready cycle
    op = OP_R;
    mem_ready = 1'b0;
    cyc(1, "r.fwait",   S_FETCH,   SB_REQ,  MX_FETCH, 2'b00);
    mem_ready = 1'b1;
    cyc(1, "r.fetch",   S_FETCH,   SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "r.dec",     S_DECODE,  SB_NONE, MX_DEC,   2'b00);
    cyc(1, "r.exec",    S_EXECR,   SB_NONE, MX_EXR,   2'b00);
    cyc(1, "r.wb",      S_ALUWB,   SB_WB,   MX_NONE,  2'b00);

    // lui, auipc, jalr, beq, jal
    op = OP_LUI;
    cyc(1, "lui.fetch", S_FETCH,   SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "lui.dec",   S_DECODE,  SB_NONE, MX_DEC,   2'b00);
    cyc(1, "lui.lui",   S_LUI,     SB_NONE, MX_LUI,   2'b00);
    cyc(1, "lui.wb",    S_ALUWB,   SB_WB,   MX_NONE,  2'b00);
    op = OP_AUIPC;
    cyc(1, "aui.fetch", S_FETCH,   SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "aui.dec",   S_DECODE,  SB_NONE, MX_DEC,   2'b00);
    cyc(1, "aui.wb",    S_ALUWB,   SB_WB,   MX_NONE,  2'b00);
    op = OP_JALR;
    cyc(1, "jalr.fetch", S_FETCH,   SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "jalr.dec",   S_DECODE,  SB_NONE, MX_DEC,   2'b00);
    cyc(1, "jalr.adr",   S_JALRADR, SB_NONE, MX_ADR,   2'b00);
    cyc(1, "jalr.jal",   S_JAL,     SB_PC,   MX_JAL,   2'b00);
    cyc(1, "jalr.wb",    S_ALUWB,   SB_WB,   MX_NONE,  2'b00);
    op = OP_BR;
    cyc(1, "br.fetch",  S_FETCH,   SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "br.dec",    S_DECODE,  SB_NONE, MX_DEC,   2'b00);
    cyc(1, "br.br",     S_BRANCH,  SB_BR,   MX_BR,    2'b00);
    op = OP_JAL;
    cyc(1, "jal.fetch", S_FETCH,   SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "jal.dec",   S_DECODE,  SB_NONE, MX_DEC,   2'b00);
    cyc(1, "jal.jal",   S_JAL,     SB_PC,   MX_JAL,   2'b00);
    cyc(1, "jal.wb",    S_ALUWB,   SB_WB,   MX_NONE,  2'b00);

    // Illegal opcode: a traps, b pulses and refetches
    op = OP_BAD;
    cyc(1, "ill.fetch", S_FETCH,   SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "ill.dec",   S_DECODE,  SB_NONE, MX_DEC,   2'b10);
    @(negedge clk);
    look(0, "ill.trap0", S_TRAP,  SB_NONE, MX_NONE,  2'b10);
    look(1, "ill.back",  S_FETCH, SB_FRDY, MX_FETCH, 2'b00);
    tick();
    for (int i = 1; i < 10; i++) begin
      cyc(0, $sformatf("ill.trap%0d", i), S_TRAP, SB_NONE, MX_NONE, 2'b10);
    end

    // Timeout: ready never arrives in FETCH
    op = OP_R;
    mem_ready = 1'b0;
    do_reset("rst.to");
    for (int i = 0; i < 4; i++) begin
      cyc(1, $sformatf("to.w%0d", i), S_FETCH, SB_REQ, MX_FETCH, 2'b00);
    end
    @(negedge clk);
    look(0, "to.trap", S_TRAP,  SB_NONE, MX_NONE,  2'b01);
    look(1, "to.wait", S_FETCH, SB_REQ,  MX_FETCH, 2'b00);
    tick();
    mem_ready = 1'b1;
    cyc(0, "to.sticky", S_TRAP, SB_NONE, MX_NONE, 2'b01);

    // Ready on the expiry cycle wins
    mem_ready = 1'b0;
    do_reset("rst.ok");
    for (int i = 0; i < 3; i++) begin
      cyc(1, $sformatf("ok.w%0d", i), S_FETCH, SB_REQ, MX_FETCH, 2'b00);
    end
    mem_ready = 1'b1;
    cyc(1, "ok.fetch",  S_FETCH,  SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "ok.dec",    S_DECODE, SB_NONE, MX_DEC,   2'b00);
    cyc(1, "ok.exec",   S_EXECR,  SB_NONE, MX_EXR,   2'b00);
    cyc(1, "ok.wb",     S_ALUWB,  SB_WB,   MX_NONE,  2'b00);

    // Async reset during a stalled store
    op = OP_SW;
    cyc(1, "ar.fetch",  S_FETCH,    SB_FRDY, MX_FETCH, 2'b00);
    cyc(1, "ar.dec",    S_DECODE,   SB_NONE, MX_DEC,   2'b00);
    cyc(1, "ar.adr",    S_MEMADR,   SB_NONE, MX_ADR,   2'b00);
    mem_ready = 1'b0;
    cyc(1, "ar.wait",   S_MEMWRITE, SB_WR,   MX_MEM,   2'b00);
    check("ar.pre.mem_write", 32'(a_mem_write), 32'd1);
    check("ar.pre.mem_req",   32'(a_mem_req),   32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("a.ar.mem_write", 32'(a_mem_write), 32'd0);
    check("a.ar.mem_req",   32'(a_mem_req),   32'd0);
    check("b.ar.mem_write", 32'(b_mem_write), 32'd0);
    check("b.ar.mem_req",   32'(b_mem_req),   32'd0);
    check("a.ar.state",     32'(a_state_o),   32'd0);
    tick();
    rst_n = 1'b1;
    cyc(1, "ar.after",  S_FETCH, SB_REQ, MX_FETCH, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
